// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared widths and NOP encoding for the fetch stage.
package fetch_stage_pkg;
  localparam int ADDR_W_DEF = 8;
  localparam int INST_W_DEF = 32;
  localparam logic [INST_W_DEF-1:0] NOP = '0;
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory bus (master = fetch: imem_addr out, imem_rdata in).
interface fetch_stage_if import fetch_stage_pkg::*; #(parameter int ADDR_W = ADDR_W_DEF, parameter int INST_W = INST_W_DEF);
  logic [ADDR_W-1:0] imem_addr;
  logic [INST_W-1:0] imem_rdata;
  modport master(output imem_addr, input imem_rdata);
  modport slave(input imem_addr, output imem_rdata);
endinterface

// File: rtl/fetch_stage_pc_next_sel.sv
// pc_next_sel: next-PC priority (branch > stall > jr > jump > pc+1); ports: pc, redirect sources in, pc_next/pc_inc/redirect/hold out.
module pc_next_sel #(parameter int ADDR_W = 8) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] jr_target,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              stall,
  input  logic              jump,
  input  logic              jr,
  input  logic              branch_taken,
  input  logic              id_valid,
  output logic [ADDR_W-1:0] pc_next,
  output logic [ADDR_W-1:0] pc_inc,
  output logic              redirect,
  output logic              hold
);
  logic jr_go, j_go;
  always_comb begin
    pc_inc = pc + ADDR_W'(1);
    jr_go = id_valid && jr && !stall;
    j_go = id_valid && jump && !stall;
    hold = stall && !branch_taken;
    redirect = branch_taken || jr_go || j_go;
    pc_next = branch_taken ? branch_target : stall ? pc : jr_go ? jr_target : j_go ? jump_target : pc_inc;
  end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC + IF/ID register; ports: clk, rst, imem (master), stall/jump/jr/branch redirects, id_inst/id_pc1/id_valid, flush_idex_o; FETCH_PERF_CNT_EN adds perf_stall_cnt/perf_redirect_cnt.
module fetch_stage import fetch_stage_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int INST_W = INST_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  fetch_stage_if.master     imem,
  input  logic              stall_i,
  input  logic              jump_i,
  input  logic              jr_i,
  input  logic [ADDR_W-1:0] jr_target_i,
  input  logic              branch_taken_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic [INST_W-1:0] id_inst,
  output logic [ADDR_W-1:0] id_pc1,
  output logic              id_valid,
  output logic              flush_idex_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]       perf_stall_cnt,
  output logic [15:0]       perf_redirect_cnt
`endif
);
  logic [ADDR_W-1:0] pc, pc_next, pc_inc;
  logic redirect, hold;
  pc_next_sel #(.ADDR_W(ADDR_W)) u_sel (
    .pc(pc), .jr_target(jr_target_i), .jump_target(id_inst[ADDR_W-1:0]),
    .branch_target(branch_target_i), .stall(stall_i), .jump(jump_i), .jr(jr_i),
    .branch_taken(branch_taken_i), .id_valid(id_valid),
    .pc_next(pc_next), .pc_inc(pc_inc), .redirect(redirect), .hold(hold)
  );
  assign imem.imem_addr = pc;
  assign flush_idex_o = branch_taken_i;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= '0;
      id_inst <= INST_W'(NOP);
      id_pc1 <= '0;
      id_valid <= 1'b0;
    end else begin
      pc <= pc_next;
      if (!hold) begin
        id_inst <= redirect ? INST_W'(NOP) : imem.imem_rdata;
        id_pc1 <= redirect ? '0 : pc_inc;
        id_valid <= !redirect;
      end
    end
  end
`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_redirect_cnt <= '0;
    end else begin
      if (hold && perf_stall_cnt != 16'hFFFF) perf_stall_cnt <= perf_stall_cnt + 16'd1;
      if (redirect && perf_redirect_cnt != 16'hFFFF) perf_redirect_cnt <= perf_redirect_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and randomized checks of fetch_stage against a behavioural model.
module tb_fetch_stage;
  logic clk = 0, rst = 1;
  logic stall = 0, jump = 0, jr = 0, br = 0;
  logic [7:0] jr_t = 0, br_t = 0;
  logic [31:0] id_inst;
  logic [7:0] id_pc1;
  logic id_valid, flush;
  logic [31:0] mem [0:255];
  logic [7:0] m_pc, m_pc1;
  logic [31:0] m_inst;
  logic m_valid;
  int m_stalls, m_redirs;
  int checks = 0, errors = 0;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] stall_cnt, redir_cnt;
`endif
  fetch_stage_if #(.ADDR_W(8), .INST_W(32)) imem ();
  assign imem.imem_rdata = mem[imem.imem_addr];
  fetch_stage #(.ADDR_W(8), .INST_W(32)) dut (
    .clk(clk), .rst(rst), .imem(imem), .stall_i(stall), .jump_i(jump), .jr_i(jr),
    .jr_target_i(jr_t), .branch_taken_i(br), .branch_target_i(br_t),
    .id_inst(id_inst), .id_pc1(id_pc1), .id_valid(id_valid), .flush_idex_o(flush)
`ifdef FETCH_PERF_CNT_EN
    , .perf_stall_cnt(stall_cnt), .perf_redirect_cnt(redir_cnt)
`endif
  );
  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc = 0; m_pc1 = 0; m_inst = 0; m_valid = 0; m_stalls = 0; m_redirs = 0;
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'(i + 100);
  endtask

  task automatic do_reset();
    @(negedge clk);
    stall = 0; jump = 0; jr = 0; br = 0;
    rst = 1; model_reset();
    #2 rst = 0;
  endtask

  // One clock edge; the model applies the next-PC rules to its own state.
  task automatic tick();
    @(posedge clk);
    if (br) begin
      m_pc = br_t; m_inst = 0; m_pc1 = 0; m_valid = 0; m_redirs++;
    end else if (stall) begin
      m_stalls++;
    end else if (m_valid && (jr || jump)) begin
      m_pc = jr ? jr_t : m_inst[7:0]; m_inst = 0; m_pc1 = 0; m_valid = 0; m_redirs++;
    end else begin
      m_inst = mem[m_pc]; m_pc1 = m_pc + 8'd1; m_valid = 1; m_pc = m_pc + 8'd1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    fill_mem();
    do_reset();
    repeat (4) tick();
    #2 rst = 1;
    #1;
    checks++;
    if (imem.imem_addr !== 8'h00 || id_inst !== 32'h0 || id_pc1 !== 8'h00 || id_valid !== 1'b0 || flush !== 1'b0) begin
      errors++;
      $display("FAIL reset: pc=%h inst=%h pc1=%h valid=%b flush=%b, want all zero", imem.imem_addr, id_inst, id_pc1, id_valid, flush);
    end
    @(negedge clk);
    rst = 0; model_reset();
  endtask

  task automatic test_seq_and_stall();
    fill_mem();
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (id_inst !== 32'(99 + i) || id_pc1 !== 8'(i) || id_valid !== 1'b1) begin
        errors++;
        $display("FAIL seq%0d: inst=%0d pc1=%0d valid=%b, want %0d %0d 1", i, id_inst, id_pc1, id_valid, 99 + i, i);
      end
    end
    repeat (2) tick();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (imem.imem_addr !== 8'd5 || id_inst !== 32'd104 || id_pc1 !== 8'd5) begin
        errors++;
        $display("FAIL stall%0d: pc=%0d inst=%0d pc1=%0d, want 5 104 5", i, imem.imem_addr, id_inst, id_pc1);
      end
    end
    stall = 0;
    tick();
    checks++;
    if (id_inst !== 32'd105 || id_pc1 !== 8'd6 || imem.imem_addr !== 8'd6) begin
      errors++;
      $display("FAIL stall_release: inst=%0d pc1=%0d pc=%0d, want 105 6 6", id_inst, id_pc1, imem.imem_addr);
    end
  endtask

  task automatic test_jump();
    fill_mem();
    mem[8] = {6'h02, 26'h40};
    do_reset();
    repeat (9) tick();
    jump = 1;
    tick();
    jump = 0;
    checks++;
    if (id_valid !== 1'b0 || imem.imem_addr !== 8'h40) begin
      errors++;
      $display("FAIL jump_bubble: valid=%b pc=%h, want 0 40", id_valid, imem.imem_addr);
    end
    tick();
    checks++;
    if (id_inst !== 32'd164 || id_pc1 !== 8'h41 || id_valid !== 1'b1) begin
      errors++;
      $display("FAIL jump_target: inst=%0d pc1=%h valid=%b, want 164 41 1", id_inst, id_pc1, id_valid);
    end
  endtask

  task automatic test_jr();
    fill_mem();
    do_reset();
    repeat (2) tick();
    jr = 1; jr_t = 8'h22;
    tick();
    jr = 0;
    checks++;
    if (id_valid !== 1'b0 || imem.imem_addr !== 8'h22) begin
      errors++;
      $display("FAIL jr_bubble: valid=%b pc=%h, want 0 22", id_valid, imem.imem_addr);
    end
    tick();
    checks++;
    if (id_inst !== 32'd134 || id_pc1 !== 8'h23) begin
      errors++;
      $display("FAIL jr_target: inst=%0d pc1=%h, want 134 23", id_inst, id_pc1);
    end
    stall = 1; jr = 1; jr_t = 8'h77;
    tick();
    stall = 0; jr = 0;
    checks++;
    if (imem.imem_addr !== 8'h23 || id_inst !== 32'd134 || id_valid !== 1'b1) begin
      errors++;
      $display("FAIL jr_during_stall: pc=%h inst=%0d valid=%b, want 23 134 1", imem.imem_addr, id_inst, id_valid);
    end
  endtask

  task automatic test_branch();
    fill_mem();
    do_reset();
    repeat (3) tick();
    br = 1; br_t = 8'h10; jump = 1; stall = 1;
    #1;
    checks++;
    if (flush !== 1'b1) begin
      errors++;
      $display("FAIL branch_flush: flush=%b, want 1", flush);
    end
    tick();
    br = 0; jump = 0; stall = 0;
    #1;
    checks++;
    if (imem.imem_addr !== 8'h10 || id_valid !== 1'b0 || id_inst !== 32'h0 || flush !== 1'b0) begin
      errors++;
      $display("FAIL branch_redirect: pc=%h valid=%b inst=%h flush=%b, want 10 0 0 0", imem.imem_addr, id_valid, id_inst, flush);
    end
    tick();
    checks++;
    if (id_inst !== 32'd116 || id_pc1 !== 8'h11) begin
      errors++;
      $display("FAIL branch_target: inst=%0d pc1=%h, want 116 11", id_inst, id_pc1);
    end
  endtask

  task automatic test_wrap();
    fill_mem();
    do_reset();
    tick();
    jr = 1; jr_t = 8'hFF;
    tick();
    jr = 0;
    tick();
    checks++;
    if (imem.imem_addr !== 8'h00 || id_pc1 !== 8'h00 || id_inst !== 32'd355 || id_valid !== 1'b1) begin
      errors++;
      $display("FAIL wrap: pc=%h pc1=%h inst=%0d valid=%b, want 00 00 355 1", imem.imem_addr, id_pc1, id_inst, id_valid);
    end
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 99));
      stall = $urandom_range(0, 3) == 0;
      br = $urandom_range(0, 9) == 0;
      br_t = 8'($urandom);
      jr_t = 8'($urandom);
      jr = r < 15;
      jump = r >= 15 && r < 30;
      #1;
      checks++;
      if (flush !== br) begin
        errors++;
        $display("FAIL rand_flush@%0d: flush=%b, want %b", n, flush, br);
      end
      tick();
      checks++;
      if (imem.imem_addr !== m_pc || id_inst !== m_inst || id_pc1 !== m_pc1 || id_valid !== m_valid) begin
        errors++;
        $display("FAIL rand@%0d: pc=%h inst=%h pc1=%h valid=%b, want %h %h %h %b", n, imem.imem_addr, id_inst, id_pc1, id_valid, m_pc, m_inst, m_pc1, m_valid);
      end
`ifdef FETCH_PERF_CNT_EN
      checks++;
      if (stall_cnt !== 16'(m_stalls) || redir_cnt !== 16'(m_redirs)) begin
        errors++;
        $display("FAIL rand_cnt@%0d: stall=%0d redir=%0d, want %0d %0d", n, stall_cnt, redir_cnt, m_stalls, m_redirs);
      end
`endif
    end
    stall = 0; br = 0; jr = 0; jump = 0;
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_perf();
    fill_mem();
    do_reset();
    tick();
    stall = 1;
    repeat (2) tick();
    stall = 0; br = 1; br_t = 8'h30;
    tick();
    br = 0;
    checks++;
    if (stall_cnt !== 16'd2 || redir_cnt !== 16'd1) begin
      errors++;
      $display("FAIL perf_counts: stall=%0d redir=%0d, want 2 1", stall_cnt, redir_cnt);
    end
    stall = 1;
    repeat (65540) tick();
    stall = 0;
    checks++;
    if (stall_cnt !== 16'hFFFF || m_stalls < 65535) begin
      errors++;
      $display("FAIL perf_saturate: stall=%h, want ffff", stall_cnt);
    end
  endtask
`endif

  initial begin
    fill_mem();
    model_reset();
    #12 rst = 0;
    test_reset();
    test_seq_and_stall();
    test_jump();
    test_jr();
    test_branch();
    test_wrap();
    test_random();
`ifdef FETCH_PERF_CNT_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
